// File: rtl/fp_conv_pkg.sv
// Shared widths and limits for the two's-complement-to-float converter.
// Used by the magnitude splitter and the stages around it.
package fp_conv_pkg;

    localparam int MAG_W = 13;
    localparam int E_W   = 3;
    localparam int F_W   = 5;
    localparam int P_W   = 4;

    localparam logic [E_W-1:0] E_MAX = 3'd7;
    localparam logic [F_W-1:0] F_MAX = 5'b11111;

    // Leading-one positions the splitter can report.
    localparam logic [P_W-1:0] P_MIN = P_W'(F_W - 1);
    localparam logic [P_W-1:0] P_TOP = P_W'(MAG_W - 1);

endpackage

// File: rtl/split_mag_lead1.sv
// Leading-one priority encoder for the magnitude splitter.
// Below bit 4 nothing is searched; p then defaults to 4.
module split_mag_lead1
    import fp_conv_pkg::*;
(
    input  logic [MAG_W-1:0] mag,
    output logic [P_W-1:0]   p,
    output logic             sat
);

    always_comb begin
        p   = P_MIN;
        sat = mag[MAG_W-1];
        // Ascending scan: the highest set bit wins.
        for (int i = int'(P_MIN); i < MAG_W; i++) begin
            if (mag[i]) begin
                p = P_W'(i);
            end
        end
    end

endmodule

// File: rtl/split_mag.sv
// Registered splitter: magnitude -> exponent, 5-bit significand and
// round bit, one cycle of latency, synchronous active-low clear.
module split_mag
    import fp_conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] Magnitude,
    output logic [E_W-1:0]   E,
    output logic [F_W-1:0]   F,
    output logic             SixthBit
);

    logic [P_W-1:0]   p;
    logic             sat;
    logic [P_W-1:0]   shamt;
    logic [MAG_W-1:0] norm;
    logic [E_W-1:0]   e_d;
    logic [F_W-1:0]   f_d;
    logic             six_d;

    split_mag_lead1 u_lead1 (
        .mag (Magnitude),
        .p   (p),
        .sat (sat)
    );

    // Left-justify the leading one; bits shifted in from below are zero,
    // which yields the p=4 round bit of 0 for free.
    assign shamt = P_TOP - p;
    assign norm  = Magnitude << shamt;

    always_comb begin
        e_d   = E_W'(p - P_MIN);
        f_d   = norm[MAG_W-1 -: F_W];
        six_d = norm[MAG_W-1-F_W];
        if (sat) begin
            e_d   = E_MAX;
            f_d   = F_MAX;
            six_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            E        <= '0;
            F        <= '0;
            SixthBit <= 1'b0;
        end else begin
            E        <= e_d;
            F        <= f_d;
            SixthBit <= six_d;
        end
    end

endmodule

// File: tb/tb_split_mag.sv
// Directed and exhaustive checks for the registered magnitude splitter.
// Outputs are sampled 1 ns after each rising edge.
module tb_split_mag;

    logic        clk;
    logic        rst_n;
    logic [12:0] Magnitude;
    logic [2:0]  E;
    logic [4:0]  F;
    logic        SixthBit;

    int tests;
    int fails;

    split_mag dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Magnitude (Magnitude),
        .E         (E),
        .F         (F),
        .SixthBit  (SixthBit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [12:0] m);
        Magnitude = m;
        @(posedge clk);
        #1;
    endtask

    // Reference: search the leading one from bit 11 down, then pick bits.
    function automatic logic [8:0] model(input logic [12:0] m);
        logic [2:0] e;
        logic [4:0] f;
        logic       six;
        if (m[12]) return {3'd7, 5'b11111, 1'b0};
        if (m < 13'd16) return {3'd0, m[4:0], 1'b0};
        e   = 3'd0;
        f   = 5'd0;
        six = 1'b0;
        for (int q = 11; q >= 4; q--) begin
            if (m[q]) begin
                e = 3'(q - 4);
                for (int j = 0; j < 5; j++) f[4-j] = m[q-j];
                six = (q >= 5) ? m[q-5] : 1'b0;
                break;
            end
        end
        return {e, f, six};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(13'h1FFF);
            tests++;
            if ({E, F, SixthBit} !== 9'd0) begin
                fails++;
                $display("FAIL reset edge%0d: got E=%0d F=%b Six=%b, want E=0 F=00000 Six=0",
                         k, E, F, SixthBit);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        logic [12:0] v [2];
        v[0] = 13'h1000;
        v[1] = 13'h1FFF;
        for (int k = 0; k < 2; k++) begin
            drive(v[k]);
            tests++;
            if ({E, F, SixthBit} !== {3'd7, 5'b11111, 1'b0}) begin
                fails++;
                $display("FAIL sat %h: got E=%0d F=%b Six=%b, want E=7 F=11111 Six=0",
                         v[k], E, F, SixthBit);
            end
        end
    endtask

    task automatic test_normal();
        logic [12:0] v   [3];
        logic [8:0]  exp [3];
        v[0] = 13'h00B4; exp[0] = {3'd3, 5'b10110, 1'b1};
        v[1] = 13'h0FFF; exp[1] = {3'd7, 5'b11111, 1'b1};
        v[2] = 13'h0800; exp[2] = {3'd7, 5'b10000, 1'b0};
        for (int k = 0; k < 3; k++) begin
            drive(v[k]);
            tests++;
            if ({E, F, SixthBit} !== exp[k]) begin
                fails++;
                $display("FAIL normal %h: got %b_%b_%b, want %b_%b_%b", v[k],
                         E, F, SixthBit, exp[k][8:6], exp[k][5:1], exp[k][0]);
            end
        end
    endtask

    task automatic test_small();
        logic [12:0] v   [4];
        logic [8:0]  exp [4];
        v[0] = 13'h000D; exp[0] = {3'd0, 5'b01101, 1'b0};
        v[1] = 13'h0000; exp[1] = {3'd0, 5'b00000, 1'b0};
        v[2] = 13'h0010; exp[2] = {3'd0, 5'b10000, 1'b0};
        v[3] = 13'h0021; exp[3] = {3'd1, 5'b10000, 1'b1};
        for (int k = 0; k < 4; k++) begin
            drive(v[k]);
            tests++;
            if ({E, F, SixthBit} !== exp[k]) begin
                fails++;
                $display("FAIL small %h: got %b_%b_%b, want %b_%b_%b", v[k],
                         E, F, SixthBit, exp[k][8:6], exp[k][5:1], exp[k][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] v   [8];
        logic [8:0]  exp [8];
        v[0] = 13'h1000; exp[0] = {3'd7, 5'b11111, 1'b0};
        v[1] = 13'h00B4; exp[1] = {3'd3, 5'b10110, 1'b1};
        v[2] = 13'h000D; exp[2] = {3'd0, 5'b01101, 1'b0};
        v[3] = 13'h0FFF; exp[3] = {3'd7, 5'b11111, 1'b1};
        v[4] = 13'h0800; exp[4] = {3'd7, 5'b10000, 1'b0};
        v[5] = 13'h0000; exp[5] = {3'd0, 5'b00000, 1'b0};
        v[6] = 13'h0010; exp[6] = {3'd0, 5'b10000, 1'b0};
        v[7] = 13'h1FFF; exp[7] = {3'd7, 5'b11111, 1'b0};
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                rst_n = 1'b0;
                drive(13'h0FFF);
                tests++;
                if ({E, F, SixthBit} !== 9'd0) begin
                    fails++;
                    $display("FAIL b2b reset: got E=%0d F=%b Six=%b, want all zero",
                             E, F, SixthBit);
                end
                rst_n = 1'b1;
            end
            drive(v[k]);
            tests++;
            if ({E, F, SixthBit} !== exp[k]) begin
                fails++;
                $display("FAIL b2b[%0d] %h: got %b_%b_%b, want %b_%b_%b", k, v[k],
                         E, F, SixthBit, exp[k][8:6], exp[k][5:1], exp[k][0]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] exp;
        for (int v = 0; v < 8192; v++) begin
            drive(13'(v));
            exp = model(13'(v));
            tests++;
            if ({E, F, SixthBit} !== exp) begin
                fails++;
                if (fails < 20)
                    $display("FAIL sweep %h: got %b_%b_%b, want %b_%b_%b", v,
                             E, F, SixthBit, exp[8:6], exp[5:1], exp[0]);
            end
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        Magnitude = 13'h1FFF;
        test_reset();
        test_saturation();
        test_normal();
        test_small();
        test_back_to_back();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
